piso_shift_reg: RTL and testbench

//   Parallel-in, serial-out shift register. It is the transmit-side counterpart of

---
 rtl/piso_shift_reg.sv | 129 ++++++++++++
 tb/tb_piso_shift_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register. One word is accepted through a valid/ready
// handshake and sent MSB- or LSB-first, one bit per enabled clock. The first bit
// appears on the first en=1 edge after the load. load_ready is high only in IDLE.
// Optional macro PARITY_BIT_EN appends an even-parity bit to every frame.
module piso_shift_reg #(
    parameter int MSB = 8,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [MSB-1:0] din,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic           dir,
    input  logic           en,
    input  logic           circular,
    output logic           q,
    output logic           q_valid,
    output logic           busy,
    output logic           done
);

    localparam logic [CW-1:0] LAST = CW'(MSB - 1);

`ifdef PARITY_BIT_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t         state, state_n;
    logic [MSB-1:0] shift_word, shift_word_n;
    logic [MSB-1:0] saved_word, saved_word_n;
    logic           dir_r, dir_n;
    logic [CW-1:0]  counter, counter_n;
    logic           q_n, q_valid_n, done_n;

    assign load_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_word <= '0;
            saved_word <= '0;
            dir_r      <= 1'b0;
            counter    <= '0;
            q          <= 1'b0;
            q_valid    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shift_word <= shift_word_n;
            saved_word <= saved_word_n;
            dir_r      <= dir_n;
            counter    <= counter_n;
            q          <= q_n;
            q_valid    <= q_valid_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        shift_word_n = shift_word;
        saved_word_n = saved_word;
        dir_n        = dir_r;
        counter_n    = counter;
        q_n          = q;
        q_valid_n    = 1'b0;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                if (load_valid && load_ready) begin
                    shift_word_n = din;
                    saved_word_n = din;
                    dir_n        = dir;
                    counter_n    = '0;
                    state_n      = SHIFT;
                end
            end

            SHIFT: begin
                if (en) begin
                    q_n          = dir_r ? shift_word[0] : shift_word[MSB-1];
                    q_valid_n    = 1'b1;
                    shift_word_n = dir_r ? (shift_word >> 1) : (shift_word << 1);
                    counter_n    = counter + 1'b1;
                    if (counter == LAST) begin
`ifdef PARITY_BIT_EN
                        // Word boundary moves to the parity edge.
                        counter_n = '0;
                        state_n   = PARITY;
`else
                        done_n = 1'b1;
                        if (circular) begin
                            shift_word_n = saved_word;
                            counter_n    = '0;
                        end else begin
                            state_n = IDLE;
                        end
`endif
                    end
                end
            end

`ifdef PARITY_BIT_EN
            PARITY: begin
                if (en) begin
                    q_n       = ^saved_word;
                    q_valid_n = 1'b1;
                    done_n    = 1'b1;
                    if (circular) begin
                        shift_word_n = saved_word;
                        counter_n    = '0;
                        state_n      = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
`endif

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (MSB=8); follows PARITY_BIT_EN when defined.
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       dir;
    logic       en;
    logic       circular;
    logic       q;
    logic       q_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    piso_shift_reg #(.MSB(8), .CW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dir        (dir),
        .en         (en),
        .circular   (circular),
        .q          (q),
        .q_valid    (q_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] w, input logic d);
        din        = w;
        dir        = d;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("load_busy", {7'd0, busy}, 8'd1);
        chk("load_qv", {7'd0, q_valid}, 8'd0);
        chk("load_rdy", {7'd0, load_ready}, 8'd0);
    endtask

    // bits[7] is the first bit expected on the wire; par is the hand-computed parity bit.
    task automatic frame(input string tag, input logic [7:0] bits, input logic par);
        for (int i = 0; i < 8; i++) begin
            step();
            chk({tag, "_q"}, {7'd0, q}, {7'd0, bits[7-i]});
            chk({tag, "_qv"}, {7'd0, q_valid}, 8'd1);
`ifdef PARITY_BIT_EN
            chk({tag, "_done"}, {7'd0, done}, 8'd0);
`else
            chk({tag, "_done"}, {7'd0, done}, (i == 7) ? 8'd1 : 8'd0);
`endif
        end
`ifdef PARITY_BIT_EN
        step();
        chk({tag, "_par"}, {7'd0, q}, {7'd0, par});
        chk({tag, "_par_qv"}, {7'd0, q_valid}, 8'd1);
        chk({tag, "_par_done"}, {7'd0, done}, 8'd1);
`else
        chk({tag, "_par_unused"}, {7'd0, par}, {7'd0, par ^ 1'b0});
`endif
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; load_valid = 1'b0; dir = 1'b0; en = 1'b1; circular = 1'b0;
        #1;
        chk("rst_q", {7'd0, q}, 8'd0);
        chk("rst_qv", {7'd0, q_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_rdy", {7'd0, load_ready}, 8'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("idle_rdy", {7'd0, load_ready}, 8'd1);

        // 1: B1 MSB-first; a competing load and din change mid-frame must be ignored
        load_word(8'hB1, 1'b0);
        din = 8'h3C; load_valid = 1'b1; dir = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t1_q", {7'd0, q}, {7'd0, 8'hB1 >> (7 - i)} & 8'd1);
            chk("t1_done", {7'd0, done}, 8'd0);
        end
        load_valid = 1'b0;
        step();
        chk("t1_q8", {7'd0, q}, 8'd1);
`ifdef PARITY_BIT_EN
        chk("t1_done8", {7'd0, done}, 8'd0);
        step();
        chk("t1_par", {7'd0, q}, 8'd0);
`endif
        chk("t1_done_last", {7'd0, done}, 8'd1);
        chk("t1_rdy_after", {7'd0, load_ready}, 8'd1);
        chk("t1_busy_after", {7'd0, busy}, 8'd0);
        step();
        chk("t1_done_pulse", {7'd0, done}, 8'd0);
        chk("t1_qv_drop", {7'd0, q_valid}, 8'd0);

        // 2: B1 LSB-first -> 1,0,0,0,1,1,0,1
        load_word(8'hB1, 1'b1);
        frame("t2", 8'b1000_1101, 1'b0);
        chk("t2_idle", {7'd0, busy}, 8'd0);

        // 3: stall two cycles after bit 3; done 10 (11 with parity) edges after load
        load_word(8'hB1, 1'b0);
        frame_start: begin
            step(); chk("t3_b1", {7'd0, q}, 8'd1);
            step(); chk("t3_b2", {7'd0, q}, 8'd0);
            step(); chk("t3_b3", {7'd0, q}, 8'd1);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t3_hold_q", {7'd0, q}, 8'd1);
            chk("t3_hold_qv", {7'd0, q_valid}, 8'd0);
            chk("t3_hold_done", {7'd0, done}, 8'd0);
            chk("t3_hold_busy", {7'd0, busy}, 8'd1);
        end
        en = 1'b1;
        step(); chk("t3_b4", {7'd0, q}, 8'd1);
        step(); chk("t3_b5", {7'd0, q}, 8'd0);
        step(); chk("t3_b6", {7'd0, q}, 8'd0);
        step(); chk("t3_b7", {7'd0, q}, 8'd0);
        chk("t3_early_done", {7'd0, done}, 8'd0);
        step(); chk("t3_b8", {7'd0, q}, 8'd1);
`ifdef PARITY_BIT_EN
        step(); chk("t3_par", {7'd0, q}, 8'd0);
`endif
        chk("t3_done", {7'd0, done}, 8'd1);
        chk("t3_qv", {7'd0, q_valid}, 8'd1);

        // 4: A5 circular for two words, back to back
        circular = 1'b1;
        load_word(8'hA5, 1'b0);
        frame("t4_w1", 8'b1010_0101, 1'b0);
        chk("t4_still_busy", {7'd0, busy}, 8'd1);
        circular = 1'b0;
        frame("t4_w2", 8'b1010_0101, 1'b0);
        chk("t4_idle", {7'd0, busy}, 8'd0);
        chk("t4_rdy", {7'd0, load_ready}, 8'd1);

        // 5: reset mid-frame, then a clean 0F
        load_word(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_ff", {7'd0, q}, 8'd1);
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_q", {7'd0, q}, 8'd0);
        chk("t5_rst_qv", {7'd0, q_valid}, 8'd0);
        chk("t5_rst_busy", {7'd0, busy}, 8'd0);
        chk("t5_rst_rdy", {7'd0, load_ready}, 8'd0);
        step();
        rst = 1'b0;
        #1;
        load_word(8'h0F, 1'b0);
        frame("t5_0f", 8'b0000_1111, 1'b0);
        chk("t5_idle", {7'd0, busy}, 8'd0);

`ifdef PARITY_BIT_EN
        // 6: odd-weight word gives parity 1
        load_word(8'h07, 1'b0);
        frame("t6_07", 8'b0000_0111, 1'b1);
        chk("t6_idle", {7'd0, busy}, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
